// File: rtl/clk_div_pkg.sv
// Shared types, reset defaults and config clamping for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CFG_W    = 8;
    localparam int DEF_DIV  = 4;
    localparam int DEF_HIGH = 2;
    localparam int DIV_MIN  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
    } cfg_t;

    // Ratios below DIV_MIN cannot produce a period with both a last cycle and a first cycle.
    function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] div, input logic [CFG_W-1:0] high);
        cfg_t c;
        c.div  = (div < CFG_W'(DIV_MIN)) ? CFG_W'(DIV_MIN) : div;
        c.high = high;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration port of the clock divider: one request selects a channel and carries a new ratio/high-time.
// Handshake: a request transfers on a posedge where cfg_valid and cfg_ready are both high; the master
// holds cfg_ch/cfg_div/cfg_high stable while cfg_valid is high and not yet accepted.
interface clk_div_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, output cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, input cfg_high, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, run state, active/shadow config and registered out/tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int RST_DIV  = DEF_DIV,
    parameter int RST_HIGH = DEF_HIGH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_en,
    input  logic        sync_start,
    input  logic        load,
    input  cfg_t        cfg_in,
    output logic        pend,
    output logic        out,
    output logic        tick,
    output chan_state_t state
);

    chan_state_t      state_n;
    logic [CFG_W-1:0] cnt, cnt_n;
    cfg_t             act, act_n, shd, shd_n;
    logic             pend_n, out_n, tick_n, apply, last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            act   <= '{div: CFG_W'(RST_DIV), high: CFG_W'(RST_HIGH)};
            shd   <= '{div: CFG_W'(RST_DIV), high: CFG_W'(RST_HIGH)};
            pend  <= 1'b0;
            out   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            act   <= act_n;
            shd   <= shd_n;
            pend  <= pend_n;
            out   <= out_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        act_n   = act;
        shd_n   = shd;
        pend_n  = pend;
        apply   = 1'b0;
        last    = (cnt == act.div - 1'b1);
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                apply = pend;
                if (ch_en) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (!ch_en) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (sync_start || last) begin
                    // A restart coinciding with a natural wrap is a single period boundary.
                    cnt_n = '0;
                    apply = pend;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (apply) begin
            act_n  = shd;
            pend_n = 1'b0;
        end
        // apply implies pend, so an accepted load never collides with an apply.
        if (load && !pend) begin
            shd_n  = clamp_cfg(cfg_in.div, cfg_in.high);
            pend_n = 1'b1;
        end
        out_n  = (state_n == ST_RUN) && (cnt_n < act_n.high);
        tick_n = (state_n == ST_RUN) && (cnt_n == act_n.div - 1'b1);
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent channels sharing one config port
// and a global phase-align strobe.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = clk_div_pkg::CFG_W,
    parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
    parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_start,
    clk_div_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] cfg_pend,
    output logic [NUM_CH-1:0] clk_div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] dbg_run
);

    logic [CNT_W-1:0] div_in, high_in;
    cfg_t             cfg_word;
    logic             ready_c;

    assign div_in   = cfg.cfg_div;
    assign high_in  = cfg.cfg_high;
    assign cfg_word = '{div: CFG_W'(div_in), high: CFG_W'(high_in)};

    // Out-of-range channel selects are accepted and dropped rather than stalling the port.
    always_comb begin
        ready_c = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) ready_c = ~cfg_pend[i];
        end
    end
    assign cfg.cfg_ready = ready_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_state_t st;
        logic        load;

        assign load = cfg.cfg_valid && (cfg.cfg_ch == CH_W'(i));

        clk_div_chan #(
            .RST_DIV  (DEF_DIV),
            .RST_HIGH (DEF_HIGH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .ch_en      (ch_en[i]),
            .sync_start (sync_start),
            .load       (load),
            .cfg_in     (cfg_word),
            .pend       (cfg_pend[i]),
            .out        (clk_div_out[i]),
            .tick       (tick[i]),
            .state      (st)
        );

        assign dbg_run[i] = (st == ST_RUN);
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed-vector bench for clk_div_multi; expected output snapshots are queued by the driver
// and compared by an independent monitor on the falling edge.
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 2;
    localparam int EW     = 3 * NUM_CH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_start;
    logic [NUM_CH-1:0] cfg_pend, clk_div_out, tick, dbg_run;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;

    // Phase-align table, cycles after the sync_start edge (ch0 4/2, ch1 6/3).
    logic [3:0] t4_out [12] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] t4_tick[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                                4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0011};

    clk_div_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

    clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_en       (ch_en),
        .sync_start  (sync_start),
        .cfg         (cfg_if),
        .cfg_pend    (cfg_pend),
        .clk_div_out (clk_div_out),
        .tick        (tick),
        .dbg_run     (dbg_run)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0] e, a;
        string         nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {cfg_if.cfg_ready, cfg_pend, tick, clk_div_out};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got rdy=%b pend=%b tick=%b out=%b, want rdy=%b pend=%b tick=%b out=%b",
                             nm, a[12], a[11:8], a[7:4], a[3:0], e[12], e[11:8], e[7:4], e[3:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc(input string nm, input logic [3:0] eo, input logic [3:0] et,
                       input logic [3:0] ep, input logic er);
        @(posedge clk);
        exp_q.push_back({er, ep, et, eo});
        name_q.push_back(nm);
        @(negedge clk);
        #1;
    endtask

    task automatic run_pattern(input string nm, input int ch, input int n,
                               input logic [15:0] op, input logic [15:0] tp);
        for (int k = 0; k < n; k++) begin
            cyc(nm, 4'(op[k]) << ch, 4'(tp[k]) << ch, 4'b0000, 1'b1);
        end
    endtask

    task automatic cfg_idle(input int ch, input logic [7:0] d, input logic [7:0] h);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CH_W'(ch);
        cfg_if.cfg_div   = d;
        cfg_if.cfg_high  = h;
        cyc("cfg_accept", 4'b0000, 4'b0000, 4'b0001 << ch, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        cyc("cfg_apply", 4'b0000, 4'b0000, 4'b0000, 1'b1);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        ch_en            = '0;
        sync_start       = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cyc("reset", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst = 1'b0;
    endtask

    // Stimulus
    initial begin
        rst              = 1'b1;
        ch_en            = '0;
        sync_start       = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;

        // Reset defaults, then ch0 at 4/2
        cyc("reset0", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        cyc("reset1", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst   = 1'b0;
        ch_en = 4'b0001;
        run_pattern("t1_default", 0, 8, 16'b0000_0000_0011_0011, 16'b0000_0000_1000_1000);

        // Mid-period reconfig to 5/3 at cnt=1
        cyc("t2_cnt0", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        cyc("t2_cnt1", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd0;
        cfg_if.cfg_div   = 8'd5;
        cfg_if.cfg_high  = 8'd3;
        cyc("t2_accept", 4'b0000, 4'b0000, 4'b0001, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        cyc("t2_old_last", 4'b0000, 4'b0001, 4'b0001, 1'b0);
        run_pattern("t2_new", 0, 10, 16'b0000_0000_1110_0111, 16'b0000_0010_0001_0000);

        // Odd divide and clamps on ch1
        do_reset();
        cfg_idle(1, 8'd3, 8'd1);
        ch_en = 4'b0010;
        run_pattern("t3_div3", 1, 6, 16'b0000_0000_0000_1001, 16'b0000_0000_0010_0100);
        do_reset();
        cfg_idle(1, 8'd1, 8'd1);
        ch_en = 4'b0010;
        run_pattern("t3_div1", 1, 4, 16'b0000_0000_0000_0101, 16'b0000_0000_0000_1010);
        do_reset();
        cfg_idle(1, 8'd4, 8'd0);
        ch_en = 4'b0010;
        run_pattern("t3_high0", 1, 8, 16'b0000_0000_0000_0000, 16'b0000_0000_1000_1000);
        do_reset();
        cfg_idle(1, 8'd6, 8'd9);
        ch_en = 4'b0010;
        run_pattern("t3_high9", 1, 12, 16'b0000_1111_1111_1111, 16'b0000_1000_0010_0000);

        // Phase alignment: ch0 4/2, ch1 6/3 started two cycles apart
        do_reset();
        cfg_idle(1, 8'd6, 8'd3);
        ch_en = 4'b0001;
        cyc("t4_c1", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        cyc("t4_c2", 4'b0001, 4'b0000, 4'b0000, 1'b1);
        ch_en = 4'b0011;
        cyc("t4_c3", 4'b0010, 4'b0000, 4'b0000, 1'b1);
        cyc("t4_c4", 4'b0010, 4'b0001, 4'b0000, 1'b1);
        cyc("t4_c5", 4'b0011, 4'b0000, 4'b0000, 1'b1);
        sync_start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc("t4_sync", t4_out[k], t4_tick[k], 4'b0000, 1'b1);
            sync_start = 1'b0;
        end

        // Disable, reconfigure while idle, re-enable on ch2
        do_reset();
        ch_en = 4'b0100;
        cyc("t5_c1", 4'b0100, 4'b0000, 4'b0000, 1'b1);
        cyc("t5_c2", 4'b0100, 4'b0000, 4'b0000, 1'b1);
        ch_en = 4'b0000;
        cyc("t5_off", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        cfg_idle(2, 8'd3, 8'd2);
        ch_en = 4'b0100;
        run_pattern("t5_reen", 2, 6, 16'b0000_0000_0001_1011, 16'b0000_0000_0010_0100);

        // Reset while ch1 is counting with a pending config
        do_reset();
        ch_en = 4'b0010;
        cyc("t6_c1", 4'b0010, 4'b0000, 4'b0000, 1'b1);
        cyc("t6_c2", 4'b0010, 4'b0000, 4'b0000, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'd1;
        cfg_if.cfg_div   = 8'd5;
        cfg_if.cfg_high  = 8'd3;
        cyc("t6_accept", 4'b0000, 4'b0000, 4'b0010, 1'b0);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b1;
        cyc("t6_rst", 4'b0000, 4'b0000, 4'b0000, 1'b1);
        rst = 1'b0;
        run_pattern("t6_after", 1, 8, 16'b0000_0000_0011_0011, 16'b0000_0000_1000_1000);

        // Final report
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
